dpi_reset_loader: RTL



---
 rtl/loom_init_pkg.sv | 20 ++
 rtl/dpi_reset_loader_init_value_reg.sv | 29 ++
 rtl/dpi_reset_loader.sv | 116 +++++++++++
 3 files changed

// File: rtl/loom_init_pkg.sv
// Shared types and helpers for the reset-time DPI init loader.
`default_nettype none

package loom_init_pkg;

  typedef enum logic [1:0] {
    ST_SETUP    = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_RUN      = 2'd3
  } state_e;

  // Id space covers NUM_CH value calls plus one setup call.
  function automatic int id_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dpi_reset_loader_init_value_reg.sv
// init_value_reg: one channel register, loadable at init, incrementing in run mode.
`default_nettype none

module init_value_reg
  import loom_init_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] value_o
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      value_o <= '0;
    end else if (load_i) begin
      value_o <= data_i;
    end else if (inc_i) begin
      value_o <= value_o + WIDTH'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/dpi_reset_loader.sv
// dpi_reset_loader: issues a setup call then one value call per channel over a
// valid/ready port, loads each returned value, then releases channels to run mode.
`default_nettype none

module dpi_reset_loader
  import loom_init_pkg::*;
#(
  parameter int                NUM_CH    = 4,
  parameter int                WIDTH     = 32,
  parameter int                ARG_W     = 32,
  parameter int                SEED_BASE = 42,
  parameter logic [NUM_CH-1:0] INC_MASK  = '1,
  parameter int                CNT_W     = 8,
  localparam int               ID_W      = id_width(NUM_CH)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  output logic                    req_valid_o,
  input  logic                    req_ready_i,
  output logic [ID_W-1:0]         req_id_o,
  output logic [ARG_W-1:0]        req_arg_o,
  input  logic                    rsp_valid_i,
  input  logic [WIDTH-1:0]        rsp_data_i,
  output logic [NUM_CH*WIDTH-1:0] value_o,
  output logic [CNT_W-1:0]        counter_o,
  output logic                    init_done_o,
  output logic                    rsp_err_o
);

  state_e           state, state_n;
  logic [ID_W-1:0]  ch, ch_n;
  logic             load, err_set, hs, run;
  logic             req_valid_n;
  logic [ID_W-1:0]  req_id_n;
  logic [ARG_W-1:0] req_arg_n;

  assign hs  = req_valid_o && req_ready_i;
  assign run = (state == ST_RUN);

  always_comb begin
    state_n = state;
    ch_n    = ch;
    load    = 1'b0;
    err_set = 1'b0;
    case (state)
      ST_SETUP: begin
        err_set = rsp_valid_i;
        if (hs) begin
          state_n = ST_REQ;
          ch_n    = '0;
        end
      end
      ST_REQ: begin
        err_set = rsp_valid_i;
        if (hs) state_n = ST_WAIT_RSP;
      end
      ST_WAIT_RSP: begin
        if (rsp_valid_i) begin
          load = 1'b1;
          if (ch == ID_W'(NUM_CH - 1)) begin
            state_n = ST_RUN;
          end else begin
            ch_n    = ch + ID_W'(1);
            state_n = ST_REQ;
          end
        end
      end
      ST_RUN:  err_set = rsp_valid_i;
      default: state_n = ST_SETUP;
    endcase

    // Request outputs are registered from the next state so they are 0 in reset
    // and hold steady while the bridge applies backpressure.
    req_valid_n = (state_n == ST_SETUP) || (state_n == ST_REQ);
    req_id_n    = (state_n == ST_SETUP) ? ID_W'(NUM_CH) : ch_n;
    req_arg_n   = (state_n == ST_SETUP) ? '0 : ARG_W'(SEED_BASE) + ARG_W'(ch_n);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= ST_SETUP;
      ch          <= '0;
      req_valid_o <= 1'b0;
      req_id_o    <= '0;
      req_arg_o   <= '0;
      init_done_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      counter_o   <= '0;
    end else begin
      state       <= state_n;
      ch          <= ch_n;
      req_valid_o <= req_valid_n;
      req_id_o    <= req_id_n;
      req_arg_o   <= req_arg_n;
      init_done_o <= (state_n == ST_RUN);
      if (err_set) rsp_err_o <= 1'b1;
      if (run) counter_o <= counter_o + CNT_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    init_value_reg #(
      .WIDTH (WIDTH)
    ) u_reg (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .load_i  (load && (ch == ID_W'(i))),
      .data_i  (rsp_data_i),
      .inc_i   (run && INC_MASK[i]),
      .value_o (value_o[i*WIDTH +: WIDTH])
    );
  end

endmodule

`default_nettype wire
